demux14_buf: RTL and testbench
==============================

Name: demux14_buf

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 selector used on the datapath.
- Accepts one word per cycle on a valid/ready input and steers it to one of four output channels.
- Each output channel has a one-entry holding register with its own valid/ready handshake.
- Sits between a single producer and four independent consumers; a stalled consumer blocks only the words addressed to it.

Parameters:
- Size, 8, data word width in bits.
- CntW, 8, width of the dispatched-word counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block can accept the offered word this cycle.
- in_sel  input  2  destination channel: 0→ch0, 1→ch1, 2→ch2, 3→ch3 (binary, same encoding as the 4:1 selector S).
- in_data  input  Size  word to dispatch.
- out_valid  output  4  bit i set = channel i holds a word.
- out_ready  input  4  bit i set = consumer i takes the word this cycle.
- out_data0, out_data1, out_data2, out_data3  output  Size  holding register of each channel.
- dispatch_cnt  output  CntW  count of words accepted since reset.

Behaviour:
- Reset (rst=1 at a clock edge), with priority over all other activity, including mid-transfer:
  - out_valid=4'b0000.
  - out_data0..3=0.
  - dispatch_cnt=0.
  - Round-robin pointer=0 (if present).
  - Any held words are dropped.
- Target channel t:
  - t=in_sel without DEMUX_RR_EN.
  - t=pointer with DEMUX_RR_EN.
- in_ready is combinational: in_ready = ~out_valid[t] | out_ready[t].
  - A full channel being drained in the same cycle accepts a new word (no bubble).
- Accept = in_valid & in_ready. On accept:
  - out_data_t <= in_data.
  - out_valid[t] <= 1.
  - dispatch_cnt <= dispatch_cnt+1, wrapping modulo 2^CntW (all-ones → 0).
- Drain of channel i = out_valid[i] & out_ready[i].
  - out_valid[i] <= 0, unless channel i is loaded in the same cycle, in which case it stays 1 with the new data.
- Latency: a word accepted at edge k is visible on out_data_t/out_valid[t] after edge k; there is no combinational in_data→out path.
- out_data_i holds its value while out_valid[i]=0. It is only overwritten on accept to channel i; it is not cleared on drain.
- Channels are independent:
  - Any subset of out_ready may be high.
  - Drains on non-target channels proceed regardless of input activity.
- in_sel/in_data are ignored when in_valid=0. in_valid=1 with in_ready=0 has no effect; the producer must hold its data.
- out_ready on a channel with out_valid=0 is ignored.

Optional Feature:
- Macro DEMUX_RR_EN.
- Defined:
  - in_sel is ignored.
  - A 2-bit pointer selects t; it resets to 0 and advances by 1 modulo 4 (3→0) on each accept only.
  - The pointer does not skip full channels: the input stalls until the pointed channel frees.
- Not defined:
  - The pointer logic is absent.
  - t=in_sel; in_sel stays a functional port.

Decomposition:
- Shared package/header holds:
  - NUM_CH=4.
  - Channel index constants CH0=2'd0, CH1=2'd1, CH2=2'd2, CH3=2'd3.
- One natural sub-module, demux_slot (parameter Size): a one-entry holding register.
  - Ports: load, data_in, drain ready, valid, data_out.
  - Instantiated four times.
- Top level contains: target decode, the in_ready mux, the counter and the optional pointer.

Test Plan:
1. Reset with all channels loaded → next cycle out_valid=0000, out_data0..3=0, dispatch_cnt=0.
2. Without RR, out_ready=1111; send 8'hA0,8'hA1,8'hA2,8'hA3 with in_sel=0,1,2,3 on consecutive cycles → each appears one cycle later on its channel, in_ready stays 1, dispatch_cnt=4.
3. out_ready[2]=0; send 8'h55 to ch2 → in_ready=1. Then send 8'h66 to ch2 → in_ready=0, out_data2 stays 8'h55. Raise out_ready[2] → 8'h66 accepted the same cycle, out_valid[2] stays 1.
4. ch1 full and stalled; send to ch0 and ch3 → both accepted, ch1 data unchanged.
5. CntW=8: accept 256 words → dispatch_cnt wraps to 0. Assert rst mid-stream with in_valid=1 → no accept that edge, everything cleared.
6. With DEMUX_RR_EN, in_sel=3 constant; send 5 words → routed ch0,ch1,ch2,ch3,ch0. Stall ch1 while the pointer is at 1 → in_ready=0 until out_ready[1] is raised.

Source files
------------

// File: rtl/demux14_buf_pkg.sv
// rtl/demux14_buf_pkg.sv - shared channel constants for the 1-to-4 registered demultiplexer
package demux14_buf_pkg;

  localparam int NUM_CH = 4;

  // Channel indices use the same binary encoding as the 4:1 selector S
  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with valid/ready output handshake
module demux_slot #(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [Size-1:0] data_in,
  input  logic            ready,
  output logic            valid,
  output logic [Size-1:0] data_out
);

  // Occupancy flag: a load wins over a simultaneous drain so the slot never bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Data is only replaced by a load; a drain leaves the last word visible
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/demux14_buf.sv
// rtl/demux14_buf.sv - registered 1-to-4 demux; DEMUX_RR_EN selects round-robin steering
module demux14_buf
  import demux14_buf_pkg::*;
#(
  parameter int Size = 8,
  parameter int CntW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_sel,
  input  logic [Size-1:0] in_data,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [Size-1:0] out_data0,
  output logic [Size-1:0] out_data1,
  output logic [Size-1:0] out_data2,
  output logic [Size-1:0] out_data3,
  output logic [CntW-1:0] dispatch_cnt
);

  logic [1:0]      tgt;
  logic            accept;
  logic [3:0]      load;
  logic [Size-1:0] slot_data [NUM_CH];

`ifdef DEMUX_RR_EN
  logic [1:0] ptr;
  logic [1:0] unused_sel;

  // Steering ignores in_sel; the pointer waits on a full channel rather than skipping it
  assign unused_sel = in_sel;
  assign tgt        = ptr;

  // Pointer advances only when a word is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= CH0;
    end else if (accept) begin
      ptr <= ptr + 2'd1;
    end
  end
`else
  assign tgt = in_sel;
`endif

  // A full target that is draining this cycle can still take the next word
  assign in_ready = ~out_valid[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_slot
      assign load[i] = accept & (tgt == 2'(i));

      demux_slot #(.Size(Size)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load[i]),
        .data_in  (in_data),
        .ready    (out_ready[i]),
        .valid    (out_valid[i]),
        .data_out (slot_data[i])
      );
    end
  endgenerate

  assign out_data0 = slot_data[CH0];
  assign out_data1 = slot_data[CH1];
  assign out_data2 = slot_data[CH2];
  assign out_data3 = slot_data[CH3];

  // Count of accepted words, wrapping naturally at 2^CntW
  always_ff @(posedge clk) begin
    if (rst) begin
      dispatch_cnt <= '0;
    end else if (accept) begin
      dispatch_cnt <= dispatch_cnt + {{(CntW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_demux14_buf.sv
// tb/tb_demux14_buf.sv - scoreboard bench for demux14_buf (default build and DEMUX_RR_EN)
module tb_demux14_buf;

  localparam int Size = 8;
  localparam int CntW = 8;
`ifdef DEMUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_sel;
  logic [Size-1:0] in_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [Size-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [CntW-1:0] dispatch_cnt;

  demux14_buf #(.Size(Size), .CntW(CntW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sel       (in_sel),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data0    (out_data0),
    .out_data1    (out_data1),
    .out_data2    (out_data2),
    .out_data3    (out_data3),
    .dispatch_cnt (dispatch_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [Size-1:0] word_q_t[$];
  word_q_t sb [4];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [3:0]      mv;
  logic [CntW-1:0] mcnt;
  logic [1:0]      mptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [Size-1:0] odata(input int i);
    case (i)
      0: odata = out_data0;
      1: odata = out_data1;
      2: odata = out_data2;
      default: odata = out_data3;
    endcase
  endfunction

  // One clock: check combinational and registered outputs against the model, then advance it
  task automatic cycle();
    logic [1:0] t;
    logic       rdy;
    logic       acc;
    logic [3:0] nv;
    #1;
    t   = RR ? mptr : in_sel;
    rdy = ~mv[t] | out_ready[t];
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("out_valid", 32'(out_valid), 32'(mv));
    check("dispatch_cnt", 32'(dispatch_cnt), 32'(mcnt));
    acc = in_valid & rdy;
    nv  = mv;
    for (int i = 0; i < 4; i++) begin
      if (mv[i] & out_ready[i]) begin
        check($sformatf("drain_data%0d", i), 32'(odata(i)),
              (sb[i].size() != 0) ? 32'(sb[i].pop_front()) : 32'hDEAD_BEEF);
        nv[i] = 1'b0;
      end
    end
    if (acc) begin
      sb[t].push_back(in_data);
      nv[t] = 1'b1;
    end
    @(posedge clk);
    if (rst) begin
      mv   = '0;
      mcnt = '0;
      mptr = '0;
      for (int i = 0; i < 4; i++) sb[i].delete();
    end else begin
      mv   = nv;
      mcnt = mcnt + CntW'(acc);
      mptr = mptr + 2'(acc);
    end
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [Size-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    cycle();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    mv = '0; mcnt = '0; mptr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Four words to four channels, all consumers ready
    out_ready = 4'b1111;
    send(2'd0, 8'hA0);
    send(2'd1, 8'hA1);
    send(2'd2, 8'hA2);
    send(2'd3, 8'hA3);
    check("cnt_after_four", 32'(dispatch_cnt), 32'd4);
    idle(1);

    // Stalled ch2: second word waits, then enters as the first drains
    out_ready = 4'b1011;
    send(2'd2, 8'h55);
    send(2'd2, 8'h66);
    cycle();
`ifndef DEMUX_RR_EN
    check("ch2_hold", 32'(out_data2), 32'h55);
`endif
    out_ready = 4'b1111;
    cycle();
`ifndef DEMUX_RR_EN
    check("ch2_reload_valid", 32'(out_valid[2]), 32'd1);
    check("ch2_reload_data", 32'(out_data2), 32'h66);
`endif
    idle(1);

    // ch1 full and stalled does not block other channels
    out_ready = 4'b1101;
    send(2'd1, 8'h77);
    send(2'd0, 8'h88);
    send(2'd3, 8'h99);
    idle(1);
`ifndef DEMUX_RR_EN
    check("ch1_unchanged", 32'(out_data1), 32'h77);
`endif
    out_ready = 4'b1111;
    idle(1);

    // Reset with every channel loaded
    out_ready = 4'b0000;
    send(2'd0, 8'h11);
    send(2'd1, 8'h22);
    send(2'd2, 8'h33);
    send(2'd3, 8'h44);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data0", 32'(out_data0), 32'd0);
    check("rst_data1", 32'(out_data1), 32'd0);
    check("rst_data2", 32'(out_data2), 32'd0);
    check("rst_data3", 32'(out_data3), 32'd0);
    check("rst_cnt", 32'(dispatch_cnt), 32'd0);
    idle(1);

    // 256 accepted words wrap the counter
    out_ready = 4'b1111;
    for (int k = 0; k < 256; k++) send(2'(k), 8'($urandom));
    check("cnt_wrap", 32'(dispatch_cnt), 32'd0);
    send(2'd1, 8'h5A);
    send(2'd2, 8'hC3);
    out_ready = 4'b0000;
    rst = 1'b1;
    send(2'd3, 8'hEE);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_cnt", 32'(dispatch_cnt), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    idle(1);

`ifdef DEMUX_RR_EN
    // Round-robin ignores in_sel and stalls on a full pointed channel
    out_ready = 4'b1111;
    for (int k = 0; k < 5; k++) send(2'd3, 8'hB0 + 8'(k));
    out_ready = 4'b1101;
    for (int k = 0; k < 4; k++) send(2'd3, 8'hC0 + 8'(k));
    check("rr_stall", 32'(in_ready), 32'd0);
    send(2'd3, 8'hD0);
    out_ready = 4'b1111;
    send(2'd3, 8'hD0);
    idle(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
